// File: rtl/clk_en_gen.sv
// clk_en_gen: local-bus programmable multi-channel clock-enable and square-wave generator.
// Defining CLK_EN_GEN_TICK_CNT_EN adds a read-only 32-bit TICK counter per channel at BASE+24+ch.
module clk_en_gen #(
    parameter int          NUM_CH    = 2,
    parameter int          DIV_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
    parameter int          RST_DIV   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lb_wr,
    input  logic              lb_rd,
    input  logic [31:0]       lb_addr,
    input  logic [31:0]       lb_wr_d,
    output logic [31:0]       lb_rd_d,
    output logic              lb_rd_rdy,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [DIV_W-1:0] RST_DIV_W    = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] RST_RELOAD_W = (RST_DIV == 0) ? '0 : DIV_W'(RST_DIV - 1);

    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  div_d   [NUM_CH];
    logic [DIV_W-1:0]  count_q [NUM_CH];
    logic [DIV_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic              rd_rdy_q, rd_rdy_d;
    logic [31:0]       rd_data_q, rd_data_d;
`ifdef CLK_EN_GEN_TICK_CNT_EN
    logic [31:0]       tick_q  [NUM_CH];
    logic [31:0]       tick_d  [NUM_CH];
`endif

    logic       addr_hit;
    logic [4:0] offset;
    logic [2:0] sel;
    logic       wr_div, wr_ctrl, wr_sync;
    logic       rd_hit;
    logic       unused_wr_d;

    assign addr_hit    = (lb_addr[31:5] == BASE_ADDR[31:5]);
    assign offset      = lb_addr[4:0];
    assign sel         = offset[2:0];
    assign wr_div      = lb_wr && addr_hit && (offset[4:3] == 2'b00);
    assign wr_ctrl     = lb_wr && addr_hit && (offset[4:3] == 2'b01);
    assign wr_sync     = lb_wr && addr_hit && (offset == 5'd16);
    assign unused_wr_d = ^lb_wr_d;

    // Counter reload value for a divisor; a divisor of 0 behaves like 1.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] div);
        return (div == '0) ? '0 : div - DIV_W'(1);
    endfunction

    // The active divisor is implicit in the counter: it is loaded from the shadow at each
    // terminal count, so shadow writes only ever shape the following period.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            div_d[ch]   = div_q[ch];
            count_d[ch] = count_q[ch];
            en_d[ch]    = en_q[ch];
            ce_d[ch]    = 1'b0;
            sq_d[ch]    = sq_q[ch];
`ifdef CLK_EN_GEN_TICK_CNT_EN
            tick_d[ch]  = tick_q[ch];
`endif
            if (wr_div && (int'(sel) == ch)) begin
                div_d[ch] = lb_wr_d[DIV_W-1:0];
            end
            if (wr_ctrl && (int'(sel) == ch)) begin
                en_d[ch] = lb_wr_d[0];
            end

            if (wr_sync && lb_wr_d[ch]) begin
                count_d[ch] = reload_of(div_q[ch]);
                sq_d[ch]    = 1'b0;
`ifdef CLK_EN_GEN_TICK_CNT_EN
                tick_d[ch]  = '0;
`endif
            end else if (!en_q[ch]) begin
                count_d[ch] = reload_of(div_q[ch]);
            end else if (count_q[ch] == '0) begin
                ce_d[ch]    = 1'b1;
                sq_d[ch]    = ~sq_q[ch];
                count_d[ch] = reload_of(div_q[ch]);
`ifdef CLK_EN_GEN_TICK_CNT_EN
                tick_d[ch]  = tick_q[ch] + 32'd1;
`endif
            end else begin
                count_d[ch] = count_q[ch] - DIV_W'(1);
            end
        end
    end

    // Whole DIV/CTRL windows answer reads (absent channels read 0) so the map is fixed.
    always_comb begin
        rd_hit    = 1'b0;
        rd_data_d = '0;
        if (addr_hit) begin
            case (offset[4:3])
                2'b00: begin
                    rd_hit = 1'b1;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (int'(sel) == ch) rd_data_d[DIV_W-1:0] = div_q[ch];
                    end
                end
                2'b01: begin
                    rd_hit = 1'b1;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (int'(sel) == ch) rd_data_d[0] = en_q[ch];
                    end
                end
                2'b10: begin
                    rd_hit = (sel == 3'd0);
                end
                default: begin
`ifdef CLK_EN_GEN_TICK_CNT_EN
                    rd_hit = 1'b1;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (int'(sel) == ch) rd_data_d = tick_q[ch];
                    end
`else
                    rd_hit = 1'b0;
`endif
                end
            endcase
        end
        rd_rdy_d = lb_rd && rd_hit;
        if (!rd_rdy_d) rd_data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                div_q[ch]   <= RST_DIV_W;
                count_q[ch] <= RST_RELOAD_W;
`ifdef CLK_EN_GEN_TICK_CNT_EN
                tick_q[ch]  <= '0;
`endif
            end
            en_q      <= '0;
            ce_q      <= '0;
            sq_q      <= '0;
            rd_rdy_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                div_q[ch]   <= div_d[ch];
                count_q[ch] <= count_d[ch];
`ifdef CLK_EN_GEN_TICK_CNT_EN
                tick_q[ch]  <= tick_d[ch];
`endif
            end
            en_q      <= en_d;
            ce_q      <= ce_d;
            sq_q      <= sq_d;
            rd_rdy_q  <= rd_rdy_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign ce        = ce_q;
    assign sq        = sq_q;
    assign lb_rd_rdy = rd_rdy_q;
    assign lb_rd_d   = rd_data_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: bus reads and ce/sq pulses are predicted into queues
// when stimulus is driven and compared as the DUT produces them.
module tb_clk_en_gen;

    localparam int          NUM_CH = 2;
    localparam int          DIV_W  = 16;
    localparam logic [31:0] BASE   = 32'h0000_0040;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              lb_wr = 1'b0;
    logic              lb_rd = 1'b0;
    logic [31:0]       lb_addr = '0;
    logic [31:0]       lb_wr_d = '0;
    logic [31:0]       lb_rd_d;
    logic              lb_rd_rdy;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;

    clk_en_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .BASE_ADDR(BASE), .RST_DIV(4)
    ) dut (
        .clk(clk), .reset(reset),
        .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
        .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
        .ce(ce), .sq(sq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic sq;
    } ce_exp_t;

    ce_exp_t     ce0_q[$];
    ce_exp_t     ce1_q[$];
    logic [31:0] rd_q[$];
    logic [1:0]  exp_sq = 2'b00;
    int          vectors = 0;
    int          miscompares = 0;
    ce_exp_t     mon_e;
    logic [31:0] mon_d;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ce(input int ch, input int first, input int period, input int count);
        ce_exp_t e;
        for (int i = 0; i < count; i++) begin
            exp_sq[ch] = ~exp_sq[ch];
            e.cyc = first + i * period;
            e.sq  = exp_sq[ch];
            if (ch == 0) ce0_q.push_back(e);
            else         ce1_q.push_back(e);
        end
    endtask

    // One bus cycle, driven at a falling edge; edge_no is the rising edge that samples it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic exp_rdy,
                                 input logic [31:0] exp_data, output int edge_no);
        edge_no = cyc + 1;
        lb_wr   = wr;
        lb_rd   = rd;
        lb_addr = addr;
        lb_wr_d = wdata;
        if (rd && exp_rdy) rd_q.push_back(exp_data);
        @(negedge clk);
        if (rd) begin
            checkOutput($sformatf("rd_rdy@%0h", addr), 32'(lb_rd_rdy), 32'(exp_rdy));
            if (!exp_rdy) checkOutput($sformatf("rd_idle_data@%0h", addr), lb_rd_d, 32'd0);
        end
        lb_wr = 1'b0;
        lb_rd = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, output int edge_no);
        applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 32'd0, edge_no);
    endtask

    task automatic read_reg(input logic [31:0] addr, input logic exp_rdy, input logic [31:0] exp);
        int unused_edge;
        applyStimulus(1'b0, 1'b1, addr, 32'd0, exp_rdy, exp, unused_edge);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard side: every ce pulse and every read response is matched against the queues.
    always @(negedge clk) begin
        if (ce[0]) begin
            if (ce0_q.size() == 0) checkOutput("ce0_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = ce0_q.pop_front();
                checkOutput("ce0_cycle", cyc, mon_e.cyc);
                checkOutput("ce0_sq", 32'(sq[0]), 32'(mon_e.sq));
            end
        end else if (ce0_q.size() != 0 && ce0_q[0].cyc <= cyc) begin
            mon_e = ce0_q.pop_front();
            checkOutput("ce0_missing", 32'd0, 32'(mon_e.cyc));
        end
        if (ce[1]) begin
            if (ce1_q.size() == 0) checkOutput("ce1_unexpected", 32'd1, 32'd0);
            else begin
                mon_e = ce1_q.pop_front();
                checkOutput("ce1_cycle", cyc, mon_e.cyc);
                checkOutput("ce1_sq", 32'(sq[1]), 32'(mon_e.sq));
            end
        end else if (ce1_q.size() != 0 && ce1_q[0].cyc <= cyc) begin
            mon_e = ce1_q.pop_front();
            checkOutput("ce1_missing", 32'd0, 32'(mon_e.cyc));
        end
        if (lb_rd_rdy) begin
            if (rd_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
            else begin
                mon_d = rd_q.pop_front();
                checkOutput("rd_data", lb_rd_d, mon_d);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, a, b, s, e, tmp;

        repeat (3) @(negedge clk);
        checkOutput("rst_ce", 32'(ce), 32'd0);
        checkOutput("rst_sq", 32'(sq), 32'd0);
        checkOutput("rst_rdy", 32'(lb_rd_rdy), 32'd0);
        checkOutput("rst_rd_d", lb_rd_d, 32'd0);
        reset = 1'b0;

        // Idle after reset: register defaults and no activity for 100 cycles.
        read_reg(BASE + 0, 1'b1, 32'd4);
        read_reg(BASE + 8, 1'b1, 32'd0);
        wait_until(cyc + 100);
        checkOutput("idle_ce", 32'(ce), 32'd0);
        checkOutput("idle_sq", 32'(sq), 32'd0);

        // ch0: DIV=4, then DIV=10 mid-period, then DIV=0 (continuous), then disable.
        write_reg(BASE + 8, 32'd1, w);
        push_ce(0, w + 4, 4, 3);
        push_ce(0, w + 22, 10, 3);
        push_ce(0, w + 43, 1, 9);
        wait_until(w + 9);
        write_reg(BASE + 0, 32'd10, tmp);
        wait_until(w + 34);
        write_reg(BASE + 0, 32'd0, tmp);
        wait_until(w + 50);
        write_reg(BASE + 8, 32'd0, tmp);
        wait_until(w + 60);

        // ch0 DIV=3 and ch1 DIV=6, then SYNC landing on a ch0 terminal count.
        write_reg(BASE + 0, 32'd3, tmp);
        write_reg(BASE + 1, 32'd6, tmp);
        write_reg(BASE + 8, 32'd1, a);
        write_reg(BASE + 9, 32'd1, b);
        for (int t = a + 3; t < a + 9; t += 3) push_ce(0, t, 3, 1);
        for (int t = b + 6; t < a + 9; t += 6) push_ce(1, t, 6, 1);
        wait_until(a + 8);
        write_reg(BASE + 16, 32'd3, s);
        checkOutput("sync_sq", 32'(sq), 32'd0);
        checkOutput("sync_ce", 32'(ce), 32'd0);
        exp_sq = 2'b00;
        push_ce(0, s + 3, 3, 4);
        push_ce(1, s + 6, 6, 2);

        // Reset mid-period with a read in flight: everything must be 0 after that edge.
        wait_until(s + 13);
        reset   = 1'b1;
        lb_rd   = 1'b1;
        lb_addr = BASE;
        @(negedge clk);
        checkOutput("midrst_ce", 32'(ce), 32'd0);
        checkOutput("midrst_sq", 32'(sq), 32'd0);
        checkOutput("midrst_rdy", 32'(lb_rd_rdy), 32'd0);
        checkOutput("midrst_rd_d", lb_rd_d, 32'd0);
        reset  = 1'b0;
        lb_rd  = 1'b0;
        exp_sq = 2'b00;

        // Register map behaviour.
        read_reg(BASE + 8, 1'b1, 32'd0);
        read_reg(BASE + 0, 1'b1, 32'd4);
        read_reg(BASE + 9, 1'b1, 32'd0);
        write_reg(BASE + 1, 32'hABCD_1234, tmp);
        read_reg(BASE + 1, 1'b1, 32'h0000_1234);
        applyStimulus(1'b1, 1'b1, BASE + 0, 32'd7, 1'b1, 32'd4, tmp);
        read_reg(BASE + 0, 1'b1, 32'd7);
        write_reg(BASE + 5, 32'h77, tmp);
        read_reg(BASE + 5, 1'b1, 32'd0);
        write_reg(BASE + 16, 32'd0, tmp);
        read_reg(BASE + 16, 1'b1, 32'd0);
        read_reg(BASE + 100, 1'b0, 32'd0);
        read_reg(BASE + 17, 1'b0, 32'd0);
`ifdef CLK_EN_GEN_TICK_CNT_EN
        read_reg(BASE + 24, 1'b1, 32'd0);
        write_reg(BASE + 0, 32'd2, tmp);
        write_reg(BASE + 8, 32'd1, e);
        push_ce(0, e + 2, 2, 100);
        wait_until(e + 200);
        read_reg(BASE + 24, 1'b1, 32'd100);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_sq = 2'b00;
        read_reg(BASE + 24, 1'b1, 32'd0);
`else
        e = 0;
        read_reg(BASE + 24, 1'b0, 32'd0);
`endif
        repeat (5) @(negedge clk);

        checkOutput("ce0_pending", 32'(ce0_q.size()), 32'd0);
        checkOutput("ce1_pending", 32'(ce1_q.size()), 32'd0);
        checkOutput("rd_pending", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
